// File: rtl/button_debounce_multi.sv
// Multi-channel pushbutton debouncer with press/release pulses and long-press detection.
// Define AUTO_REPEAT_EN to make btn_long fire repeatedly every REPEAT_CYCLES while held.
module button_debounce_multi #(
   parameter int NUM_BTN           = 5,
   parameter int DEBOUNCE_CYCLES   = 1_000_000,
   parameter int LONG_PRESS_CYCLES = 100_000_000,
   parameter int REPEAT_CYCLES     = 20_000_000,
   parameter bit ACTIVE_LOW        = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_long,
   output logic [NUM_BTN-1:0] btn_held
);

   localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LIM  = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
   localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
`endif

   logic [NUM_BTN-1:0] raw;
   logic [NUM_BTN-1:0] sync1_q, sync1_d;
   logic [NUM_BTN-1:0] sync2_q, sync2_d;
   logic [NUM_BTN-1:0] level_q, level_d;
   logic [NUM_BTN-1:0] press_q, press_d;
   logic [NUM_BTN-1:0] release_q, release_d;
   logic [NUM_BTN-1:0] long_q, long_d;
   logic [NUM_BTN-1:0] held_q, held_d;
   logic [CNT_W-1:0]   cnt_q  [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d  [NUM_BTN];
   logic [HOLD_W-1:0]  hold_q [NUM_BTN];
   logic [HOLD_W-1:0]  hold_d [NUM_BTN];

   // Polarity correction puts every channel into the 1 = pressed domain.
   assign raw = btn_in ^ {NUM_BTN{ACTIVE_LOW}};

   always_comb begin
      sync1_d   = raw;
      sync2_d   = sync1_q;
      level_d   = level_q;
      press_d   = '0;
      release_d = '0;
      long_d    = '0;
      held_d    = held_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (sync2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == DEB_LAST) begin
            level_d[i]   = sync2_q[i];
            cnt_d[i]     = '0;
            press_d[i]   = sync2_q[i];
            release_d[i] = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end

         // Hold counter reads 0 in the press cycle and counts while the level stays high.
         if (!level_q[i] || release_d[i]) begin
            hold_d[i] = '0;
            held_d[i] = 1'b0;
`ifdef AUTO_REPEAT_EN
         end else if (hold_q[i] == (held_q[i] ? REP_LAST : LONG_LAST)) begin
            long_d[i] = 1'b1;
            held_d[i] = 1'b1;
            hold_d[i] = '0;
`else
         end else if (hold_q[i] == LONG_LIM) begin
            hold_d[i] = hold_q[i];
         end else if (hold_q[i] == LONG_LAST) begin
            long_d[i] = 1'b1;
            held_d[i] = 1'b1;
            hold_d[i] = LONG_LIM;
`endif
         end else begin
            hold_d[i] = hold_q[i] + HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         long_q    <= '0;
         held_q    <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            cnt_q[i]  <= '0;
            hold_q[i] <= '0;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
         held_q    <= held_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;
   assign btn_long    = long_q;
   assign btn_held    = held_q;

endmodule
